// File: rtl/ro_freq_meter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ro_freq_meter_if
//  Description : Measurement handshake bundle of ro_freq_meter.
//                start         - request a measurement (consumer -> meter)
//                busy          - measurement in progress (meter -> consumer)
//                done          - one-cycle pulse, count/ovf updated
//                count[CNT_W]  - rising edges seen in the last window
//                ovf           - last window saturated the counter
//                Modport "master" is the consumer side, "slave" the meter.
//  Revision    : 1.0  initial release
// ============================================================================
interface ro_freq_meter_if #(
  parameter int CNT_W = 26
);
  logic             start;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic             ovf;

  modport master (
    output start,
    input  busy,
    input  done,
    input  count,
    input  ovf
  );

  modport slave (
    input  start,
    output busy,
    output done,
    output count,
    output ovf
  );
endinterface
`default_nettype wire

// File: rtl/ro_freq_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ro_freq_meter
//  Description : Ring-oscillator frequency meter for PUF response logic.
//                Enables the RO, lets it settle, then counts its rising
//                edges over a fixed window of clk cycles and reports the
//                count through a start/busy/done handshake.
//  Ports       : clk    - global clock
//                rst    - asynchronous reset, active-high
//                ro_in  - raw RO output, asynchronous to clk
//                ro_en  - registered, glitch-free enable to the RO
//                bus    - handshake bundle (start/busy/done/count/ovf)
//  Revision    : 1.0  initial release
// ============================================================================
module ro_freq_meter #(
  parameter int CNT_W         = 26,
  parameter int WINDOW        = 2**20,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ro_in,
  output logic              ro_en,
  ro_freq_meter_if.slave    bus
);

  localparam int c_win_w = $clog2(WINDOW + 1);
  localparam int c_set_w = $clog2(SETTLE_CYCLES + 1);

  localparam logic [c_win_w-1:0] c_win_last = c_win_w'(WINDOW - 1);
  localparam logic [c_set_w-1:0] c_set_last = c_set_w'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   c_acc_max  = {CNT_W{1'b1}};

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_settle  = 2'd1;
  localparam logic [1:0] c_st_measure = 2'd2;
  localparam logic [1:0] c_st_done    = 2'd3;

  logic [1:0]         r_state;
  logic [c_set_w-1:0] r_set_cnt;
  logic [c_win_w-1:0] r_win_cnt;
  logic [CNT_W-1:0]   r_acc;
  logic               r_sat;
  logic [CNT_W-1:0]   r_count;
  logic               r_ovf;
  logic               r_done;
  logic               r_busy;
  logic               r_ro_en;

  logic               r_s1;
  logic               r_s2;
  logic               r_s3;
  logic               w_edge;

  logic [CNT_W-1:0]   w_acc_nxt;
  logic               w_sat_nxt;

  // --------------------------------------------------------------------------
  // RO synchroniser. s1/s2 resolve metastability; s3 is the delayed copy used
  // for rising-edge detection. ROs faster than clk/2 alias undetected.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= ro_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge = r_s2 & ~r_s3;

  // --------------------------------------------------------------------------
  // Saturating accumulator step. At full scale the count freezes and any
  // further edge only raises the sticky saturation flag.
  // --------------------------------------------------------------------------
  always_comb begin
    w_acc_nxt = r_acc;
    w_sat_nxt = r_sat;
    if (w_edge) begin
      if (r_acc == c_acc_max) begin
        w_sat_nxt = 1'b1;
      end else begin
        w_acc_nxt = r_acc + CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM. Outputs are registered and updated alongside the state so
  // that ro_en never glitches and count/ovf are already valid in the DONE
  // cycle: the last MEASURE cycle loads them with the final accumulator step.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_st_idle;
      r_set_cnt <= '0;
      r_win_cnt <= '0;
      r_acc     <= '0;
      r_sat     <= 1'b0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_ro_en   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (bus.start) begin
            r_state   <= c_st_settle;
            r_acc     <= '0;
            r_sat     <= 1'b0;
            r_set_cnt <= '0;
            r_win_cnt <= '0;
            r_busy    <= 1'b1;
            r_ro_en   <= 1'b1;
          end
        end

        // RO runs and the synchroniser flushes; edges here are not counted.
        c_st_settle: begin
          if (r_set_cnt == c_set_last) begin
            r_state   <= c_st_measure;
            r_set_cnt <= '0;
          end else begin
            r_set_cnt <= r_set_cnt + c_set_w'(1);
          end
        end

        c_st_measure: begin
          r_acc <= w_acc_nxt;
          r_sat <= w_sat_nxt;
          if (r_win_cnt == c_win_last) begin
            r_state <= c_st_done;
            r_count <= w_acc_nxt;
            r_ovf   <= w_sat_nxt;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_ro_en <= 1'b0;
          end else begin
            r_win_cnt <= r_win_cnt + c_win_w'(1);
          end
        end

        // Single result cycle; a held start is only re-sampled from IDLE,
        // which yields one IDLE cycle between back-to-back measurements.
        c_st_done: begin
          r_state <= c_st_idle;
        end

        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign ro_en     = r_ro_en;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.count = r_count;
  assign bus.ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ro_freq_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ro_freq_meter
//  Description : Bench for ro_freq_meter. Two instances: A (CNT_W=26,
//                WINDOW=1000) and B (CNT_W=4, WINDOW=100), both with a
//                16-cycle settle. Each start pushes its expected result into
//                a queue; a per-instance monitor pops and compares on done.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ro_freq_meter;

  localparam int S   = 16;
  localparam int WA  = 1000;
  localparam int WB  = 100;
  localparam int PER = S + WA + 2;  // done-to-done spacing with start held

  typedef struct {
    int cyc;
    int cnt;
    int tol;
    bit ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  logic ro_a = 1'b0, ro_b = 1'b0;
  logic ro_en_a, ro_en_b;
  int   mode_a = 0;   // 0 = oscillate, 1 = stuck 0, 2 = stuck 1
  int   mode_b = 0;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];

  ro_freq_meter_if #(.CNT_W(26)) bus_a ();
  ro_freq_meter_if #(.CNT_W(4))  bus_b ();

  ro_freq_meter #(.CNT_W(26), .WINDOW(WA), .SETTLE_CYCLES(S)) dut_a (
    .clk   (clk),
    .rst   (rst_a),
    .ro_in (ro_a),
    .ro_en (ro_en_a),
    .bus   (bus_a)
  );

  ro_freq_meter #(.CNT_W(4), .WINDOW(WB), .SETTLE_CYCLES(S)) dut_b (
    .clk   (clk),
    .rst   (rst_b),
    .ro_in (ro_b),
    .ro_en (ro_en_b),
    .bus   (bus_b)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // RO models: A period 40ns, B period 30ns, offset 3ns from the enabling edge
  always begin
    if (ro_en_a === 1'b1 && mode_a == 0) begin
      #20 ro_a = ~ro_a;
    end else begin
      ro_a = (mode_a == 2);
      @(ro_en_a or mode_a);
      #3;
    end
  end

  always begin
    if (ro_en_b === 1'b1 && mode_b == 0) begin
      #15 ro_b = ~ro_b;
    end else begin
      ro_b = (mode_b == 2);
      @(ro_en_b or mode_b);
      #3;
    end
  end

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    exp_t e;
    int   d;
    if (rst_a === 1'b0 && bus_a.done === 1'b1) begin
      if (sb_a.size() == 0) begin
        chk(1'b0, "a_unexpected_done", cyc, -1);
      end else begin
        e = sb_a.pop_front();
        d = int'(bus_a.count) - e.cnt;
        chk(cyc == e.cyc, "a_done_cycle", cyc, e.cyc);
        chk(d <= e.tol && d >= -e.tol, "a_count", bus_a.count, e.cnt);
        chk(bus_a.ovf == e.ovf, "a_ovf", bus_a.ovf, e.ovf);
        chk(bus_a.busy == 1'b0 && ro_en_a == 1'b0, "a_done_busy_roen", {bus_a.busy, ro_en_a}, 0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    int   d;
    if (rst_b === 1'b0 && bus_b.done === 1'b1) begin
      if (sb_b.size() == 0) begin
        chk(1'b0, "b_unexpected_done", cyc, -1);
      end else begin
        e = sb_b.pop_front();
        d = int'(bus_b.count) - e.cnt;
        chk(cyc == e.cyc, "b_done_cycle", cyc, e.cyc);
        chk(d <= e.tol && d >= -e.tol, "b_count", bus_b.count, e.cnt);
        chk(bus_b.ovf == e.ovf, "b_ovf", bus_b.ovf, e.ovf);
        chk(bus_b.busy == 1'b0 && ro_en_b == 1'b0, "b_done_busy_roen", {bus_b.busy, ro_en_b}, 0);
      end
    end
  end

  // One-cycle start pulse driven from a negedge; done is due 1+S+W cycles on
  task automatic pulse(input bit sel, input int cnt, input int tol, input bit ovf);
    exp_t e;
    @(negedge clk);
    e.cnt = cnt;
    e.tol = tol;
    e.ovf = ovf;
    if (sel) begin
      e.cyc = cyc + 1 + S + WB;
      sb_b.push_back(e);
      bus_b.start = 1'b1;
    end else begin
      e.cyc = cyc + 1 + S + WA;
      sb_a.push_back(e);
      bus_a.start = 1'b1;
    end
    @(negedge clk);
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  task automatic wait_empty(input bit sel, input int budget);
    int n = 0;
    while ((sel ? sb_b.size() : sb_a.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk(1'b0, sel ? "b_done_timeout" : "a_done_timeout", n, budget);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int bad;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    chk(!ro_en_a && !bus_a.busy && !bus_a.done && bus_a.count == 0 && !bus_a.ovf,
        "a_reset_state", {ro_en_a, bus_a.busy, bus_a.done, bus_a.ovf}, 0);
    chk(!ro_en_b && !bus_b.busy && !bus_b.done && bus_b.count == 0 && !bus_b.ovf,
        "b_reset_state", {ro_en_b, bus_b.busy, bus_b.done, bus_b.ovf}, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // 1) nominal measurement: 40ns RO over 1000 x 10ns -> 250 edges
    pulse(1'b0, 250, 1, 1'b0);
    wait_empty(1'b0, 1200);

    // 2) 4-bit counter, 30ns RO over 100 cycles -> saturates at 15
    pulse(1'b1, 15, 0, 1'b1);
    wait_empty(1'b1, 300);

    // 3) second start mid-MEASURE is ignored: one result, no late done
    pulse(1'b0, 250, 1, 1'b0);
    repeat (300) @(negedge clk);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    wait_empty(1'b0, 1200);
    repeat (1100) @(negedge clk);

    // 4) reset mid-MEASURE clears outputs at once, then a clean measurement
    pulse(1'b0, 250, 1, 1'b0);
    repeat (500) @(negedge clk);
    #2 rst_a = 1'b1;
    #1;
    chk(!ro_en_a && !bus_a.busy && !bus_a.done && bus_a.count == 0,
        "a_async_reset", {ro_en_a, bus_a.busy, bus_a.done}, 0);
    sb_a.delete();
    @(negedge clk);
    rst_a = 1'b0;
    pulse(1'b0, 250, 1, 1'b0);
    wait_empty(1'b0, 1200);

    // 5) stuck RO (0 then 1): zero count, done still on schedule
    mode_a = 1;
    repeat (5) @(negedge clk);
    pulse(1'b0, 0, 0, 1'b0);
    wait_empty(1'b0, 1200);
    mode_a = 2;
    repeat (5) @(negedge clk);
    pulse(1'b0, 0, 0, 1'b0);
    wait_empty(1'b0, 1200);
    mode_a = 0;
    repeat (5) @(negedge clk);

    // 6) start held for three windows: dones every PER cycles, ro_en low
    //    only in the DONE and IDLE cycle of each round
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e.cyc = cyc + 1 + S + WA + k * PER;
      e.cnt = 250;
      e.tol = 1;
      e.ovf = 1'b0;
      sb_a.push_back(e);
    end
    bus_a.start = 1'b1;
    bad = 0;
    for (int c = 1; c <= 3 * PER - 1; c++) begin
      @(negedge clk);
      if (ro_en_a !== (((c - 1) % PER) < (S + WA))) bad++;
    end
    bus_a.start = 1'b0;
    chk(bad == 0, "a_roen_pattern_held_start", bad, 0);
    wait_empty(1'b0, 100);
    repeat (5) @(negedge clk);
    chk(bus_a.busy == 1'b0, "a_no_fourth_run", bus_a.busy, 0);

    chk(sb_a.size() == 0, "a_pending_results", sb_a.size(), 0);
    chk(sb_b.size() == 0, "b_pending_results", sb_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
